// File: rtl/decode_instruction_pkg.sv
// decode_instruction_pkg: widths, instruction field layout, opecode constants and write-back decode
package decode_instruction_pkg;
  localparam int ADDR = 16;
  localparam int W_INST = 32;
  localparam int W_OPC = 7;
  localparam int W_OPR = 32;
  localparam int W_RD = 5;
  localparam int W_IMM = 16;
  localparam int W_IMM_RAW = 15;
  typedef struct packed {
    logic [W_OPC-1:0] opc;
    logic [W_RD-1:0] rd;
    logic [W_RD-1:0] rs;
    logic [W_IMM_RAW-1:0] imm;
  } inst_t;
  localparam logic [W_OPC-1:0] OPC_LD = 7'b1000000;
  localparam logic [W_OPC-1:0] OPC_ST = 7'b1000001;
  localparam logic [4:0] FN_CMP = 5'd4;
  // Bit 5 selects the immediate form for operand 1; bits 6:5 = 11 is the jump/NOP/HLT class
  function automatic logic wb_enable(input logic [W_OPC-1:0] opc);
    logic [4:0] fn;
    fn = opc[4:0];
    return opc == OPC_LD ? 1'b1 :
           opc[6] ? 1'b0 :
           !(fn == FN_CMP || fn == 5'd11 || fn == 5'd14 || fn == 5'd15 || fn >= 5'd20);
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 2^W_RD x W_OPR register file, two async read ports with write-through, one write port
// Ports: clk, reset (async active-low clears all entries), we/wa/wd write port, ra0/ra1 -> rd0/rd1
module decode_regfile
  import decode_instruction_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [W_RD-1:0]  wa,
  input  logic [W_OPR-1:0] wd,
  input  logic [W_RD-1:0]  ra0,
  input  logic [W_RD-1:0]  ra1,
  output logic [W_OPR-1:0] rd0,
  output logic [W_OPR-1:0] rd1
);
  logic [W_OPR-1:0] mem [2**W_RD];
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < 2**W_RD; i++) mem[i] <= '0;
    else if (we)
      mem[wa] <= wd;
  // Same-cycle write wins so a reader never sees stale data
  assign rd0 = (we && wa == ra0) ? wd : mem[ra0];
  assign rd1 = (we && wa == ra1) ? wd : mem[ra1];
endmodule

// File: rtl/decode_instruction.sv
// decode_instruction: decode/register-read stage feeding execute, with RAW interlock, squash and stall
// Ports: clk, reset (async active-low); fetch side v_i/inst_i/pc_i/stall_o; execute side stall_i,
// branch_i, write-back wb_i/wb_r_i/result_i; registered bundle v_o/pc_o/opecode_o/opr0_o/opr1_o/imm_o/wb_o/wb_r_o
module decode_instruction
  import decode_instruction_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              v_i,
  input  logic [W_INST-1:0] inst_i,
  input  logic [ADDR-1:0]   pc_i,
  input  logic              stall_i,
  output logic              stall_o,
  input  logic              branch_i,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   wb_r_i,
  input  logic [W_OPR-1:0]  result_i,
  output logic              v_o,
  output logic [ADDR-1:0]   pc_o,
  output logic [W_OPC-1:0]  opecode_o,
  output logic [W_OPR-1:0]  opr0_o,
  output logic [W_OPR-1:0]  opr1_o,
  output logic [W_IMM-1:0]  imm_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   wb_r_o
);
  inst_t f;
  logic [W_OPR-1:0] rd_val, rs_val, imm_opr;
  logic [W_IMM-1:0] imm_ext;
  logic hazard;
  assign f = inst_t'(inst_i);
  assign imm_ext = {{(W_IMM-W_IMM_RAW){f.imm[W_IMM_RAW-1]}}, f.imm};
  assign imm_opr = {{(W_OPR-W_IMM_RAW){f.imm[W_IMM_RAW-1]}}, f.imm};
  decode_regfile u_rf (
    .clk(clk), .reset(reset),
    .we(wb_i), .wa(wb_r_i), .wd(result_i),
    .ra0(f.rd), .ra1(f.rs),
    .rd0(rd_val), .rd1(rs_val)
  );
  // The instruction in the output register has not yet written back; one bubble lets it reach write-back
  assign hazard = v_i & v_o & wb_o & (wb_r_o == f.rd | (wb_r_o == f.rs & ~f.opc[5]));
  assign stall_o = stall_i | (hazard & ~branch_i);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v_o <= 1'b0;
      pc_o <= '0;
      opecode_o <= '0;
      opr0_o <= '0;
      opr1_o <= '0;
      imm_o <= '0;
      wb_o <= 1'b0;
      wb_r_o <= '0;
    end else if (!stall_i) begin
      if (branch_i | hazard)
        v_o <= 1'b0;
      else begin
        v_o <= v_i;
        if (v_i) begin
          pc_o <= pc_i;
          opecode_o <= f.opc;
          opr0_o <= rd_val;
          opr1_o <= f.opc[5] ? imm_opr : rs_val;
          imm_o <= imm_ext;
          wb_o <= wb_enable(f.opc);
          wb_r_o <= f.rd;
        end
      end
    end
endmodule

// File: tb/tb_decode_instruction.sv
// tb_decode_instruction: directed + randomized checks of decode_instruction against a behavioural model
module tb_decode_instruction;
  logic clk = 0, reset = 0;
  logic v_i = 0, stall_i = 0, branch_i = 0, wb_i = 0;
  logic [31:0] inst_i = 0, result_i = 0;
  logic [15:0] pc_i = 0;
  logic [4:0] wb_r_i = 0;
  logic stall_o, v_o, wb_o;
  logic [15:0] pc_o, imm_o;
  logic [6:0] opecode_o;
  logic [31:0] opr0_o, opr1_o;
  logic [4:0] wb_r_o;
  int tests = 0, fails = 0;
  logic [31:0] regs [32];
  logic mv = 0, mwb = 0;
  logic [4:0] mwbr = 0;
  logic [15:0] mpc = 0, mimm = 0;
  logic [6:0] mopc = 0;
  logic [31:0] mopr0 = 0, mopr1 = 0;
  localparam logic [6:0] ADD = 7'b0000000;
  localparam logic [6:0] ADDI = 7'b0100000;
  decode_instruction dut (
    .clk(clk), .reset(reset), .v_i(v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_i(stall_i), .stall_o(stall_o), .branch_i(branch_i),
    .wb_i(wb_i), .wb_r_i(wb_r_i), .result_i(result_i),
    .v_o(v_o), .pc_o(pc_o), .opecode_o(opecode_o), .opr0_o(opr0_o), .opr1_o(opr1_o),
    .imm_o(imm_o), .wb_o(wb_o), .wb_r_o(wb_r_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic m_wb(input logic [6:0] o);
    if (o == 7'b1000000) return 1'b1;
    if (o[6]) return 1'b0;
    return !(o[4:0] inside {5'd4, 5'd11, 5'd14, 5'd15, [5'd20:5'd31]});
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] idx);
    return (wb_i && wb_r_i == idx) ? result_i : regs[idx];
  endfunction
  function automatic logic m_hz();
    return v_i && mv && mwb && (mwbr == inst_i[24:20] || (!inst_i[30] && mwbr == inst_i[19:15]));
  endfunction
  task automatic m_clear();
    for (int i = 0; i < 32; i++) regs[i] = 0;
    {mv, mwb, mwbr, mpc, mimm, mopc, mopr0, mopr1} = '0;
  endtask
  task automatic m_step();
    logic hz;
    hz = m_hz();
    if (!stall_i) begin
      if (branch_i || hz) mv = 0;
      else begin
        mv = v_i;
        if (v_i) begin
          mopc = inst_i[31:25];
          mwbr = inst_i[24:20];
          mpc = pc_i;
          mopr0 = m_read(inst_i[24:20]);
          mimm = 16'($signed(inst_i[14:0]));
          mopr1 = inst_i[30] ? 32'($signed(inst_i[14:0])) : m_read(inst_i[19:15]);
          mwb = m_wb(inst_i[31:25]);
        end
      end
    end
    if (wb_i) regs[wb_r_i] = result_i;
  endtask
  always @(negedge clk) begin
    chk("stall_o", {31'b0, stall_o}, {31'b0, stall_i | (m_hz() & ~branch_i)});
    chk("v_o", {31'b0, v_o}, {31'b0, mv});
    if (mv) begin
      chk("wb_o", {31'b0, wb_o}, {31'b0, mwb});
      chk("wb_r_o", {27'b0, wb_r_o}, {27'b0, mwbr});
      chk("pc_o", {16'b0, pc_o}, {16'b0, mpc});
      chk("opecode_o", {25'b0, opecode_o}, {25'b0, mopc});
      chk("opr0_o", opr0_o, mopr0);
      chk("opr1_o", opr1_o, mopr1);
      chk("imm_o", {16'b0, imm_o}, {16'b0, mimm});
    end
  end
  task automatic drive(input logic v, input logic [31:0] inst, input logic [15:0] pc, input logic st,
                       input logic br, input logic wb, input logic [4:0] wr, input logic [31:0] res);
    v_i = v; inst_i = inst; pc_i = pc; stall_i = st; branch_i = br;
    wb_i = wb; wb_r_i = wr; result_i = res;
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) m_clear(); else m_step();
    #1;
  endtask
  task automatic cyc(input logic v, input logic [31:0] inst, input logic [15:0] pc, input logic st,
                     input logic br, input logic wb, input logic [4:0] wr, input logic [31:0] res);
    drive(v, inst, pc, st, br, wb, wr, res);
    tick();
  endtask
  initial begin
    m_clear();
    repeat (2) tick();
    chk("reset v_o", {31'b0, v_o}, 32'd0);
    chk("reset wb_o", {31'b0, wb_o}, 32'd0);
    chk("reset opr0_o", opr0_o, 32'd0);
    reset = 1;
    cyc(0, 0, 0, 0, 0, 1, 5'd3, 32'h1234);
    cyc(1, {ADD, 5'd3, 5'd3, 15'd0}, 16'h10, 0, 0, 0, 0, 0);
    chk("add opr0", opr0_o, 32'h1234);
    chk("add opr1", opr1_o, 32'h1234);
    chk("add wb_o", {31'b0, wb_o}, 32'd1);
    chk("add wb_r_o", {27'b0, wb_r_o}, 32'd3);
    cyc(1, {ADD, 5'd1, 5'd2, 15'd0}, 16'h14, 0, 0, 0, 0, 0);
    chk("zero r1", opr0_o, 32'd0);
    chk("zero r2", opr1_o, 32'd0);
    cyc(1, {ADDI, 5'd4, 5'd5, 15'h7FFF}, 16'h18, 0, 0, 0, 0, 0);
    chk("imm opr1", opr1_o, 32'hFFFF_FFFF);
    chk("imm imm_o", {16'b0, imm_o}, 32'h0000_FFFF);
    cyc(1, {ADD, 5'd5, 5'd6, 15'd0}, 16'h1C, 0, 0, 0, 0, 0);
    drive(1, {ADD, 5'd5, 5'd8, 15'd0}, 16'h20, 0, 0, 0, 0, 0);
    #1 chk("hazard stall_o", {31'b0, stall_o}, 32'd1);
    tick();
    chk("bubble v_o", {31'b0, v_o}, 32'd0);
    cyc(1, {ADD, 5'd5, 5'd8, 15'd0}, 16'h20, 0, 0, 1, 5'd5, 32'hBEEF);
    chk("consumer v_o", {31'b0, v_o}, 32'd1);
    chk("consumer bypass", opr0_o, 32'hBEEF);
    cyc(1, {ADD, 5'd8, 5'd9, 15'd0}, 16'h24, 0, 1, 0, 0, 0);
    chk("squash v_o", {31'b0, v_o}, 32'd0);
    cyc(1, {ADD, 5'd10, 5'd11, 15'd0}, 16'h28, 0, 0, 0, 0, 0);
    cyc(1, {ADD, 5'd12, 5'd12, 15'd0}, 16'h2C, 1, 1, 0, 0, 0);
    chk("stall>branch v_o", {31'b0, v_o}, 32'd1);
    chk("stall>branch wb_r_o", {27'b0, wb_r_o}, 32'd10);
    repeat (3) begin
      cyc(1, {ADD, 5'd12, 5'd12, 15'd0}, 16'h2C, 1, 0, 1, 5'd7, 32'hA5);
      chk("stall hold pc_o", {16'b0, pc_o}, 32'h28);
    end
    cyc(1, {ADD, 5'd7, 5'd13, 15'd0}, 16'h30, 0, 0, 0, 0, 0);
    chk("r7 after stall", opr0_o, 32'hA5);
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 0;
        m_clear();
      end
      if (i == 1503) reset = 1;
      cyc($urandom_range(0, 3) != 0,
          {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 15'($urandom)},
          16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
          1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end
    @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
